// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth helper and read-mode selectors.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one clock, registered read port.
// Only the read register is reset so a cleared FIFO presents zero data.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(AW);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO over a registered-read RAM with standard or
// first-word-fall-through read mode and registered status flags.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DW     = 8,
   parameter int AW     = 4,
   parameter int FWFT   = 0,
   parameter int AF_LVL = fifo_depth(AW) - 2,
   parameter int AE_LVL = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [DW-1:0] din_i,
   input  logic          rd_en_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          almost_full_o,
   output logic          almost_empty_o,
   output logic [AW:0]   count_o,
   output logic          overflow_o,
   output logic          underflow_o
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(fifo_depth(AW));
   localparam logic [AW:0] AF_W    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] AE_W    = (AW+1)'(AE_LVL);

   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full_q, af_q, ae_q, ovf_q, udf_q;
   logic          wr_acc, rd_acc, ram_re;
   logic [DW-1:0] ram_rdata;

   assign wr_acc = wr_en_i && !full_q && !rst_i;

   fifo_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_acc),
      .waddr_i (wptr_q),
      .wdata_i (din_i),
      .re_i    (ram_re),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // RAM read register acts as a prefetch slot (mid) ahead of the
         // output stage, so pops can run at one word per cycle.
         logic          mid_vld_q, out_vld_q, out_load;
         logic [DW-1:0] dout_q;
         logic [AW:0]   ram_words;

         assign rd_acc    = rd_en_i && out_vld_q && !rst_i;
         assign out_load  = mid_vld_q && (!out_vld_q || rd_acc);
         assign ram_words = count_q - {{AW{1'b0}}, out_vld_q} - {{AW{1'b0}}, mid_vld_q};
         assign ram_re    = !rst_i && (ram_words != '0) && (!mid_vld_q || out_load);

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               mid_vld_q <= 1'b0;
               out_vld_q <= 1'b0;
               dout_q    <= '0;
            end else begin
               if (ram_re)        mid_vld_q <= 1'b1;
               else if (out_load) mid_vld_q <= 1'b0;
               if (out_load) begin
                  out_vld_q <= 1'b1;
                  dout_q    <= ram_rdata;
               end else if (rd_acc) begin
                  out_vld_q <= 1'b0;
               end
            end
         end

         assign dout_o  = dout_q;
         assign empty_o = !out_vld_q;
      end else begin : g_std
         logic empty_q;

         assign rd_acc = rd_en_i && !empty_q && !rst_i;
         assign ram_re = rd_acc;

         always_ff @(posedge clk_i) begin
            empty_q <= (count_d == '0);
         end

         assign dout_o  = ram_rdata;
         assign empty_o = empty_q;
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      if (rst_i) begin
         count_d = '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Flags come from count_d so they line up with count_q every cycle.
   always_ff @(posedge clk_i) begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_W);
      af_q    <= (count_d >= AF_W);
      ae_q    <= (count_d <= AE_W);
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (wr_acc) wptr_q <= wptr_q + AW'(1);
         if (ram_re) rptr_q <= rptr_q + AW'(1);
         ovf_q <= wr_en_i && full_q;
         udf_q <= rd_en_i && !rd_acc;
      end
   end

   assign full_o         = full_q;
   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

endmodule
